frame_buffer_writer: RTL and testbench
======================================

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 Parameters (one per line):
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in lines
- PIX_W, 8, grayscale pixel width
- ADDR_W, 15, frame-buffer word address width
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock, 25 MHz display clock domain
- reset_n  in  1  asynchronous, active-low reset
- s_pixel  in  PIX_W  incoming grayscale pixel
- s_valid  in  1  s_pixel valid
- s_sof  in  1  start-of-frame marker, qualified by s_valid
- s_ready  out  1  writer can accept a pixel
- vblank  in  1  display vertical blanking, synchronous to clk
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  frame-buffer write address, 0..IMG_W*IMG_H-1
- wr_data  out  PIX_W  frame-buffer write data
- wr_bank  out  1  bank being written
- disp_bank  out  1  bank the display reads
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
- err_sof  out  1  one-cycle pulse when s_sof arrives mid-frame

Function
REQ-003 A transfer occurs on a rising clk edge with s_valid=1 and s_ready=1; no other beat has any effect.
REQ-004 FSM states: IDLE, WRITE, WAIT_SWAP.
REQ-005 s_ready is 1 in IDLE and WRITE, and 0 in WAIT_SWAP.
REQ-006 In IDLE, a transfer with s_sof=0 is discarded: no write, no pulse.
REQ-007 In IDLE, a transfer with s_sof=1 writes the pixel at address 0 and moves to WRITE.
REQ-008 In WRITE, each transfer writes at the next sequential address.
- x and y counters plus an incrementing address register are used; no multiplier.
- x wraps at IMG_W-1 to 0 and increments y.
REQ-009 In WRITE, a transfer with s_sof=1 pulses err_sof, rewrites the pixel at address 0 and restarts the counters; the FSM stays in WRITE.
REQ-010 The transfer at x=IMG_W-1, y=IMG_H-1 (address 19199) is written, pulses frame_done on the same cycle as its wr_en, and moves to WAIT_SWAP.
REQ-011 Write latency is 1 cycle: wr_en, wr_addr and wr_data are registered and assert on the cycle after the transfer.
- wr_en is 0 in every cycle with no preceding transfer.
REQ-012 In WAIT_SWAP, on the first cycle with vblank=1:
- disp_bank takes the value of wr_bank;
- wr_bank toggles;
- the FSM returns to IDLE.
- If vblank is already 1 on entry, the swap occurs on that first WAIT_SWAP cycle.
REQ-013 wr_bank and disp_bank change only in the REQ-012 swap; they are never equal after a swap.
REQ-014 Because s_ready=0 in WAIT_SWAP, s_valid in that state is ignored and s_pixel is not consumed.

Reset
REQ-015 Asserting reset_n=0 sets, asynchronously:
- FSM=IDLE; x=y=address=0;
- wr_en=0, wr_addr=0, wr_data=0;
- wr_bank=0, disp_bank=1;
- frame_done=0, err_sof=0.
REQ-016 Reset mid-frame abandons the partial frame; no swap occurs.
REQ-017 After reset_n returns to 1, the first write requires a new s_sof.

Structure
REQ-018 IMG_W, IMG_H, PIX_W, ADDR_W and the FSM state encoding live in a shared package, used also by the display address generator and the image ROM/RAM wrapper.
REQ-019 One sub-module, frame_addr_counter, holds the x/y counters and address register, with clear, increment and last-pixel flag.

Verification
REQ-020 Bench scenarios (stimulus -> required response):
- Reset release, send 19200 pixels (first with s_sof), data = address mod 256, vblank=0 -> wr_addr 0..19199 in order; wr_data matches; frame_done pulses once on the address-19199 write; s_ready=0 afterwards.
- Then pulse vblank=1 for one cycle -> same cycle edge: disp_bank=0, wr_bank=1, FSM IDLE, s_ready=1.
- In IDLE, send 5 pixels with s_sof=0, then 1 pixel with s_sof=1 -> no writes for the first 5; one write at address 0 for the sof pixel.
- Send 300 pixels, then a pixel with s_sof=1 -> err_sof pulses once; that pixel is written at address 0; the next pixel is written at address 1.
- Random s_valid gaps at 30% duty across a full frame -> exactly 19200 writes, contiguous addresses, no duplicates.
- Assert reset_n=0 at pixel 10000 with vblank held 1 -> all outputs take their reset values immediately; no swap; a new frame starts at address 0 only after an s_sof.

Source files
------------

// File: rtl/frame_buffer_writer_pkg.sv
// frame_buffer_writer_pkg: shared image geometry, pixel/address widths and the writer FSM encoding.
// Shared with the display address generator and the image ROM/RAM wrapper.
package frame_buffer_writer_pkg;
  localparam int IMG_W  = 160;
  localparam int IMG_H  = 120;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 15;
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE      = 2'd0;
  localparam fsm_state_t ST_WRITE     = 2'd1;
  localparam fsm_state_t ST_WAIT_SWAP = 2'd2;
endpackage

// File: rtl/frame_buffer_writer_addr_counter.sv
// frame_addr_counter: x/y raster position plus linear address of the next pixel to be written.
// Ports: clk, reset_n (async active-low); clr zeroes the position, inc advances it (clr+inc gives position 1);
//        addr is the current linear address, last flags x=COLS-1,y=ROWS-1.
module frame_addr_counter #(
  parameter int COLS = frame_buffer_writer_pkg::IMG_W,
  parameter int ROWS = frame_buffer_writer_pkg::IMG_H,
  parameter int AW   = frame_buffer_writer_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          last
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  logic [XW-1:0] x, bx, nx;
  logic [YW-1:0] y, by, ny;
  logic [AW-1:0] ba, na;
  logic          x_end;
  // Clear is applied before the increment so a restart can land directly on position 1.
  always_comb begin
    bx    = clr ? '0 : x;
    by    = clr ? '0 : y;
    ba    = clr ? '0 : addr;
    x_end = bx == XW'(COLS - 1);
    nx    = !inc ? bx : x_end ? '0 : bx + 1'b1;
    ny    = inc && x_end ? by + 1'b1 : by;
    na    = inc ? ba + 1'b1 : ba;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else begin
      x    <= nx;
      y    <= ny;
      addr <= na;
    end
  assign last = x == XW'(COLS - 1) && y == YW'(ROWS - 1);
endmodule

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: streams grayscale pixels into one bank of a double-buffered frame store,
// swapping banks with the display during vertical blanking.
// Ports: clk, reset_n (async active-low); s_pixel/s_valid/s_sof/s_ready pixel stream in;
//        vblank from display; wr_en/wr_addr/wr_data registered write port; wr_bank/disp_bank bank select;
//        frame_done, err_sof one-cycle pulses aligned with the corresponding write.
module frame_buffer_writer #(
  parameter int IMG_W  = frame_buffer_writer_pkg::IMG_W,
  parameter int IMG_H  = frame_buffer_writer_pkg::IMG_H,
  parameter int PIX_W  = frame_buffer_writer_pkg::PIX_W,
  parameter int ADDR_W = frame_buffer_writer_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PIX_W-1:0]  s_pixel,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_bank,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              err_sof
);
  import frame_buffer_writer_pkg::*;
  fsm_state_t        state, state_n;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last, xfer, restart, wr, fin, swap;
  assign s_ready = state != ST_WAIT_SWAP;
  assign xfer    = s_valid & s_ready;
  // Any accepted sof restarts the frame at address 0, whether idle or mid-frame.
  assign restart = xfer & s_sof;
  assign wr      = restart | (xfer & state == ST_WRITE);
  assign fin     = wr & !restart & cnt_last;
  assign swap    = state == ST_WAIT_SWAP & vblank;
  always_comb
    state_n = swap ? ST_IDLE : fin ? ST_WAIT_SWAP : restart ? ST_WRITE : state;
  frame_addr_counter #(
    .COLS (IMG_W),
    .ROWS (IMG_H),
    .AW   (ADDR_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (restart | fin),
    .inc     (wr & !fin),
    .addr    (cnt_addr),
    .last    (cnt_last)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_bank    <= 1'b0;
      disp_bank  <= 1'b1;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      state      <= state_n;
      wr_en      <= wr;
      frame_done <= fin;
      err_sof    <= restart & state == ST_WRITE;
      if (wr) begin
        wr_addr <= restart ? '0 : cnt_addr;
        wr_data <= s_pixel;
      end
      if (swap) begin
        disp_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed + randomized stimulus against a pixel-index reference model.
module tb_frame_buffer_writer;
  import frame_buffer_writer_pkg::*;
  localparam int N = IMG_W * IMG_H;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [PIX_W-1:0] s_pixel = '0;
  logic s_valid = 1'b0, s_sof = 1'b0, vblank = 1'b0;
  logic s_ready, wr_en, wr_bank, disp_bank, frame_done, err_sof;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0] wr_data;
  int checks = 0, failures = 0;
  int n_wr = 0, n_fd = 0, n_err = 0;
  int m_mode, m_pos;
  logic m_wr_en, m_fd, m_err, m_wb, m_db;
  logic [ADDR_W-1:0] m_addr;
  logic [PIX_W-1:0] m_data;

  frame_buffer_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .vblank     (vblank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_bank    (wr_bank),
    .disp_bank  (disp_bank),
    .frame_done (frame_done),
    .err_sof    (err_sof)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: mode 0 = waiting for sof, 1 = filling a frame, 2 = frame complete awaiting vblank.
  task automatic model_reset();
    m_mode = 0; m_pos = 0;
    m_wr_en = 0; m_fd = 0; m_err = 0;
    m_wb = 0; m_db = 1;
    m_addr = '0; m_data = '0;
  endtask

  function automatic logic [31:0] obs();
    return 32'({wr_en, wr_addr, wr_data, frame_done, err_sof, s_ready, wr_bank, disp_bank});
  endfunction

  function automatic logic [31:0] expv();
    return 32'({m_wr_en, m_addr, m_data, m_fd, m_err, m_mode != 2, m_wb, m_db});
  endfunction

  task automatic cycle(input logic v, input logic sof, input logic [PIX_W-1:0] pix, input logic vb);
    s_valid = v; s_sof = sof; s_pixel = pix; vblank = vb;
    @(posedge clk);
    m_wr_en = 0; m_fd = 0; m_err = 0;
    if (m_mode == 2) begin
      if (vb) begin
        m_db = m_wb;
        m_wb = ~m_wb;
        m_mode = 0;
      end
    end else if (v && sof) begin
      m_err = m_mode == 1;
      m_wr_en = 1; m_addr = '0; m_data = pix;
      m_pos = 1; m_mode = 1;
    end else if (v && m_mode == 1) begin
      m_wr_en = 1; m_addr = ADDR_W'(m_pos); m_data = pix;
      if (m_pos == N - 1) begin
        m_fd = 1;
        m_mode = 2;
      end
      m_pos++;
    end
    #1;
    n_wr += int'(wr_en);
    n_fd += int'(frame_done);
    n_err += int'(err_sof);
    chk($sformatf("cycle@%0t", $time), obs(), expv());
  endtask

  initial begin
    int i;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", obs(), expv());
    chk("reset_wr_bank", 32'(wr_bank), 32'd0);
    chk("reset_disp_bank", 32'(disp_bank), 32'd1);
    reset_n = 1'b1;
    // Full frame, data = address mod 256, no blanking.
    n_wr = 0; n_fd = 0;
    for (int k = 0; k < N; k++) cycle(1'b1, k == 0, PIX_W'(k % 256), 1'b0);
    chk("frame1_writes", n_wr, N);
    chk("frame1_done", n_fd, 1);
    chk("frame1_ready_low", 32'(s_ready), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 8'h55, 1'b0);
    chk("wait_ignores_valid", n_wr, N);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("swap_disp_bank", 32'(disp_bank), 32'd0);
    chk("swap_wr_bank", 32'(wr_bank), 32'd1);
    chk("swap_ready", 32'(s_ready), 32'd1);
    // Idle drops non-sof pixels.
    n_wr = 0;
    repeat (5) cycle(1'b1, 1'b0, PIX_W'($urandom), 1'b0);
    chk("idle_nosof_writes", n_wr, 0);
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("sof_wr_en", 32'(wr_en), 32'd1);
    chk("sof_wr_addr", 32'(wr_addr), 32'd0);
    // Mid-frame sof restarts at address 0.
    repeat (300) cycle(1'b1, 1'b0, PIX_W'($urandom), 1'b0);
    chk("pre_err_addr", 32'(wr_addr), 32'd300);
    n_err = 0;
    cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    chk("err_sof_pulse", 32'(err_sof), 32'd1);
    chk("err_sof_addr", 32'(wr_addr), 32'd0);
    chk("err_sof_data", 32'(wr_data), 32'h3C);
    cycle(1'b1, 1'b0, 8'h11, 1'b0);
    chk("after_err_addr", 32'(wr_addr), 32'd1);
    chk("err_sof_once", n_err, 1);
    // Full frame with ~30% idle beats; starts with a mid-frame sof.
    n_wr = 0; n_fd = 0;
    i = 0;
    while (i < N) begin
      if ($urandom_range(99) < 30) cycle(1'b0, 1'b0, PIX_W'($urandom), 1'b0);
      else begin
        cycle(1'b1, i == 0, PIX_W'($urandom), 1'b0);
        i++;
      end
    end
    chk("gap_frame_writes", n_wr, N);
    chk("gap_frame_done", n_fd, 1);
    // vblank already high on the first WAIT_SWAP cycle.
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("swap2_disp_bank", 32'(disp_bank), 32'd1);
    chk("swap2_wr_bank", 32'(wr_bank), 32'd0);
    // Reset mid-frame with vblank held high.
    cycle(1'b1, 1'b1, PIX_W'($urandom), 1'b1);
    for (int k = 1; k < 10000; k++) cycle(1'b1, 1'b0, PIX_W'($urandom), 1'b1);
    chk("pre_reset_addr", 32'(wr_addr), 32'd9999);
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("async_reset_outputs", obs(), expv());
    repeat (2) @(posedge clk);
    #1;
    chk("held_reset_outputs", obs(), expv());
    reset_n = 1'b1;
    n_wr = 0;
    repeat (5) cycle(1'b1, 1'b0, PIX_W'($urandom), 1'b1);
    chk("post_reset_nosof_writes", n_wr, 0);
    chk("post_reset_no_swap", 32'({wr_bank, disp_bank}), 32'b01);
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    chk("post_reset_sof_addr", 32'(wr_addr), 32'd0);
    chk("post_reset_sof_en", 32'(wr_en), 32'd1);
    repeat (4) cycle(1'b1, 1'b0, PIX_W'($urandom), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
